// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding, accumulator type and requantiser for conv_mac_array.
// acc_t is the widest accumulator any instance may use. Each engine sign-extends its
// 2*WIDTH sum into acc_t, so one requant() serves every WIDTH choice.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int ACC_MAX_W = 64;
  typedef logic signed [ACC_MAX_W-1:0] acc_t;

  // Arithmetic right shift by frac. Then either a ReLU clamp at zero or a signed
  // saturation to a width-bit range. The caller keeps the low width bits.
  function automatic acc_t requant(acc_t s, int frac, int width, bit relu);
    acc_t q;
    acc_t hi;
    acc_t lo;
    q  = s >>> frac;
    hi = (acc_t'(1) <<< (width - 1)) - acc_t'(1);
    lo = -hi - acc_t'(1);
    if (relu && (q < acc_t'(0))) return acc_t'(0);
    if (q > hi) return hi;
    if (q < lo) return lo;
    return q;
  endfunction

endpackage

// File: rtl/mac_pe.sv
// mac_pe: one output-channel MAC lane of conv_mac_array.
// Latency: operands are captured on the accept edge. The accumulator updates on the next edge.
// Backpressure: none of its own. load_i/step_i come from the top, so a stall freezes the lane.
// Ports: clk/rst; load_i captures pix_i/ker_i/first_i; step_i applies the captured
//        operands to the accumulator; acc_o is the 2*WIDTH running sum.
module mac_pe #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               first_i,
  input  logic [WIDTH-1:0]   pix_i,
  input  logic [WIDTH-1:0]   ker_i,
  input  logic               step_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic signed [WIDTH-1:0]   pix_q;
  logic signed [WIDTH-1:0]   ker_q;
  logic                      first_q;
  logic signed [2*WIDTH-1:0] acc_q;
  logic signed [2*WIDTH-1:0] acc_d;
  logic signed [2*WIDTH-1:0] prod;

  always_comb begin
    prod  = (2*WIDTH)'(pix_q) * (2*WIDTH)'(ker_q);
    acc_d = acc_q;
    // The first tap overwrites instead of adding. That clears the previous pixel
    // without an idle cycle between pixels.
    if (step_i) acc_d = first_q ? prod : acc_q + prod;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q   <= '0;
      ker_q   <= '0;
      first_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      if (load_i) begin
        pix_q   <= pix_i;
        ker_q   <= ker_i;
        first_q <= first_i;
      end
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/conv_mac_array.sv
// conv_mac_array: one output pixel across NUM_PE channels per NTAP accepted ifm beats.
// Processing: bias, requantisation and optional ReLU are applied to each pixel.
// Latency: ofm_valid pulses 2 edges after the last tap of a pixel is accepted.
// Backpressure: ifm_ready is high only in RUN. ifm_valid low stalls the taps, but never
//               the output stage. A held done blocks the next run until done_ack.
// Ports: start/busy/done/done_ack handle run control. ifm_valid/ifm_ready/ifm carry the
//        activation stream. w_addr/w_data form the combinational weight ROM port.
//        bias is the per-lane bias. ofm/ofm_valid carry the quantised pixel.
module conv_mac_array
  import conv_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_PE     = 368,
  parameter int CHIN       = 112,
  parameter int KERNEL_DIM = 1,
  parameter int NUM_PIX    = 64,
  parameter int FRAC       = 14,
  parameter int RELU_EN    = 1,
  localparam int NTAP      = KERNEL_DIM * KERNEL_DIM * CHIN,
  localparam int TAP_W     = (NTAP > 1) ? $clog2(NTAP) : 1,
  localparam int PIX_W     = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ifm_valid,
  output logic               ifm_ready,
  input  logic [WIDTH-1:0]   ifm,
  output logic [TAP_W-1:0]   w_addr,
  input  logic [WIDTH-1:0]   w_data [NUM_PE],
  input  logic [2*WIDTH-1:0] bias   [NUM_PE],
  output logic [WIDTH-1:0]   ofm    [NUM_PE],
  output logic               ofm_valid,
  output logic               busy,
  output logic               done,
  input  logic               done_ack
);

  state_t             state_q, state_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic               drain_q, drain_d;

  logic               accept;
  logic               first_tap;
  logic               last_tap;
  logic               last_pix;

  // Per-beat pipeline tags shared by all lanes.
  logic               s0_vld_q;   // operands captured last edge, the lanes step this edge
  logic               s0_last_q;  // the captured operands are the last tap of a pixel
  logic               s1_last_q;  // the accumulators now hold a finished pixel

  logic [2*WIDTH-1:0]        acc   [NUM_PE];
  logic signed [2*WIDTH-1:0] sum   [NUM_PE];
  logic [WIDTH-1:0]          ofm_d [NUM_PE];
  logic [WIDTH-1:0]          ofm_q [NUM_PE];
  logic                      ofm_valid_q;

  assign accept    = ifm_valid && (state_q == RUN);
  assign first_tap = (tap_q == '0);
  assign last_tap  = (tap_q == TAP_W'(NTAP - 1));
  assign last_pix  = (pix_q == PIX_W'(NUM_PIX - 1));

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    pix_d   = pix_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (accept) begin
          if (last_tap) begin
            tap_d = '0;
            if (last_pix) begin
              pix_d   = '0;
              drain_d = 1'b0;
              state_d = DRAIN;
            end else begin
              pix_d = pix_q + 1'b1;
            end
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
      end
      // Two cycles let the final tap reach the accumulator and then the ofm register.
      DRAIN: begin
        if (drain_q) begin
          drain_d = 1'b0;
          state_d = DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      DONE: if (done_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      pix_q       <= '0;
      drain_q     <= 1'b0;
      s0_vld_q    <= 1'b0;
      s0_last_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      ofm_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      pix_q       <= pix_d;
      drain_q     <= drain_d;
      s0_vld_q    <= accept;
      if (accept) s0_last_q <= last_tap;
      s1_last_q   <= s0_vld_q && s0_last_q;
      ofm_valid_q <= s1_last_q;
    end
  end

  for (genvar g = 0; g < NUM_PE; g++) begin : g_pe
    mac_pe #(.WIDTH(WIDTH)) u_pe (
      .clk     (clk),
      .rst     (rst),
      .load_i  (accept),
      .first_i (first_tap),
      .pix_i   (ifm),
      .ker_i   (w_data[g]),
      .step_i  (s0_vld_q),
      .acc_o   (acc[g])
    );
  end

  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      sum[i]   = signed'(acc[i]) + signed'(bias[i]);
      ofm_d[i] = WIDTH'(requant(acc_t'(sum[i]), FRAC, WIDTH, RELU_EN != 0));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PE; i++) begin
      if (rst)            ofm_q[i] <= '0;
      else if (s1_last_q) ofm_q[i] <= ofm_d[i];
    end
  end

  assign ifm_ready = (state_q == RUN);
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign w_addr    = tap_q;
  assign ofm       = ofm_q;
  assign ofm_valid = ofm_valid_q;

endmodule
